// File: rtl/menu_input.sv
// Joystick front end: synchronises and debounces button/up/down contacts,
// emits a one-cycle enter pulse and keeps the wrapping menu cursor.
module menu_input #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int NUM_OPTIONS     = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_raw,
   input  logic       up_raw,
   input  logic       down_raw,
   input  logic       menu_active,
   output logic       enter,
   output logic [1:0] value
);

   localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]      OPT_LAST = 2'(NUM_OPTIONS - 1);
   localparam int              BTN      = 0;
   localparam int              UP       = 1;
   localparam int              DN       = 2;

   logic [2:0]    w_raw;
   logic [2:0]    w_rise;
   logic [2:0]    r_sync1;
   logic [2:0]    r_sync2;
   logic [2:0]    r_stable;
   logic [2:0]    r_stable_prev;
   logic [CW-1:0] r_cnt [3];
   logic          r_menu_d;
   logic          r_enter;
   logic          r_up_rise;
   logic          r_down_rise;
   logic [1:0]    r_value;
   logic [1:0]    w_value_nxt;

   assign w_raw  = {down_raw, up_raw, btn_raw};
   assign w_rise = r_stable & ~r_stable_prev;

   // Any sample matching the accepted level restarts the run, so only an
   // uninterrupted run of DEBOUNCE_CYCLES differing samples flips it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1       <= '0;
         r_sync2       <= '0;
         r_stable      <= '0;
         r_stable_prev <= '0;
         for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1       <= w_raw;
         r_sync2       <= r_sync1;
         r_stable_prev <= r_stable;
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_stable[i] <= r_sync2[i];
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Cursor edges are registered alongside enter, so a move lands one edge
   // after a coincident enter and the FSM latches the pre-move selection.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_enter     <= 1'b0;
         r_up_rise   <= 1'b0;
         r_down_rise <= 1'b0;
         r_menu_d    <= 1'b0;
         r_value     <= '0;
      end else begin
         r_enter     <= w_rise[BTN];
         r_up_rise   <= w_rise[UP];
         r_down_rise <= w_rise[DN];
         r_menu_d    <= menu_active;
         r_value     <= w_value_nxt;
      end
   end

   always_comb begin
      w_value_nxt = r_value;
      if (menu_active && !r_menu_d) begin
         w_value_nxt = '0;
      end else if (menu_active && !(r_up_rise && r_down_rise)) begin
         if (r_down_rise) begin
            w_value_nxt = (r_value == OPT_LAST) ? 2'd0 : r_value + 2'd1;
         end else if (r_up_rise) begin
            w_value_nxt = (r_value == 2'd0) ? OPT_LAST : r_value - 2'd1;
         end
      end
   end

   assign enter = r_enter;
   assign value = r_value;

endmodule

// File: tb/tb_menu_input.sv
// Bench for menu_input (DEBOUNCE_CYCLES=4, NUM_OPTIONS=3): vector table of
// debounced presses plus hand-timed sequences, enter pulses scored by queue.
module tb_menu_input;

   logic       clock;
   logic       reset;
   logic       btn_raw;
   logic       up_raw;
   logic       down_raw;
   logic       menu_active;
   logic       enter;
   logic [1:0] value;

   int         checks   = 0;
   int         failures = 0;
   int         n_pulses = 0;
   logic [1:0] exp_q[$];
   logic [1:0] mon_exp;

   typedef struct {
      logic       btn;
      logic       up;
      logic       down;
      logic       menu;
      logic [1:0] exp_value;
      int         exp_pulses;
   } vec_t;

   vec_t vecs[12];

   menu_input #(
      .DEBOUNCE_CYCLES(4),
      .NUM_OPTIONS    (3)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_raw    (btn_raw),
      .up_raw     (up_raw),
      .down_raw   (down_raw),
      .menu_active(menu_active),
      .enter      (enter),
      .value      (value)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Each observed enter pulse must match the next queued expectation.
   always @(negedge clock) begin
      if (enter === 1'b1) begin
         n_pulses++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL enter_unexpected value=%0d required=no pulse", value);
         end else begin
            mon_exp = exp_q.pop_front();
            if (value !== mon_exp) begin
               failures++;
               $display("FAIL enter_value actual=%0d required=%0d", value, mon_exp);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic b, input logic u, input logic d);
      btn_raw  = b;
      up_raw   = u;
      down_raw = d;
      repeat (6) step();
      btn_raw  = 1'b0;
      up_raw   = 1'b0;
      down_raw = 1'b0;
      repeat (12) step();
   endtask

   // Opens the menu exactly in the cycle the registered down edge is live.
   task automatic gate_open(input logic [1:0] prev, input string tag);
      menu_active = 1'b0;
      repeat (2) step();
      down_raw = 1'b1;
      repeat (7) step();
      chk({tag, "_before_open"}, int'(value), int'(prev));
      menu_active = 1'b1;
      step();
      chk({tag, "_open_edge"}, int'(value), 0);
      step();
      chk({tag, "_open_after"}, int'(value), 0);
      down_raw = 1'b0;
      repeat (12) step();
      chk({tag, "_settled"}, int'(value), 0);
   endtask

   initial begin
      int p0;

      vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 0};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 0};

      reset       = 1'b0;
      btn_raw     = 1'b0;
      up_raw      = 1'b0;
      down_raw    = 1'b0;
      menu_active = 1'b0;
      repeat (2) step();
      chk("reset_enter", int'(enter), 0);
      chk("reset_value", int'(value), 0);
      reset = 1'b1;
      repeat (2) step();
      chk("post_reset_value", int'(value), 0);

      // Clean press: raw high before edge 1, pulse only after edge 7.
      exp_q.push_back(2'd0);
      btn_raw = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         chk($sformatf("clean_enter_e%0d", i), int'(enter), int'(i == 7));
      end
      btn_raw = 1'b0;
      repeat (12) step();
      p0 = n_pulses;
      exp_q.push_back(2'd0);
      btn_raw = 1'b1;
      repeat (20) step();
      btn_raw = 1'b0;
      repeat (12) step();
      chk("second_press_pulses", n_pulses - p0, 1);

      // Bounce and a too-short press never produce a pulse.
      p0 = n_pulses;
      for (int i = 0; i < 10; i++) begin
         btn_raw = (i % 2 == 0);
         step();
      end
      btn_raw = 1'b0;
      repeat (12) step();
      btn_raw = 1'b1;
      repeat (3) step();
      btn_raw = 1'b0;
      repeat (12) step();
      chk("bounce_pulses", n_pulses - p0, 0);

      for (int v = 0; v < 12; v++) begin
         p0          = n_pulses;
         menu_active = vecs[v].menu;
         if (vecs[v].btn) exp_q.push_back(vecs[v].exp_value);
         press(vecs[v].btn, vecs[v].up, vecs[v].down);
         chk($sformatf("vec%0d_value", v), int'(value), int'(vecs[v].exp_value));
         chk($sformatf("vec%0d_pulses", v), n_pulses - p0, vecs[v].exp_pulses);
      end

      gate_open(2'd2, "gateA");
      press(1'b0, 1'b0, 1'b1);
      chk("gate_prep_value", int'(value), 1);
      gate_open(2'd1, "gateB");

      // Enter and an up move land together: FSM must see the old cursor.
      press(1'b0, 1'b0, 1'b1);
      chk("coin_prep_value", int'(value), 1);
      exp_q.push_back(2'd1);
      btn_raw = 1'b1;
      up_raw  = 1'b1;
      repeat (7) step();
      chk("coin_enter", int'(enter), 1);
      chk("coin_value_enter_cycle", int'(value), 1);
      step();
      chk("coin_enter_next", int'(enter), 0);
      chk("coin_value_next", int'(value), 0);
      btn_raw = 1'b0;
      up_raw  = 1'b0;
      repeat (12) step();

      // Async reset while a pulse is live, then re-debounce of a held button.
      press(1'b0, 1'b1, 1'b0);
      chk("areset_prep_value", int'(value), 2);
      btn_raw = 1'b1;
      repeat (7) step();
      chk("areset_pre_enter", int'(enter), 1);
      #2;
      reset = 1'b0;
      #1;
      chk("areset_enter", int'(enter), 0);
      chk("areset_value", int'(value), 0);
      repeat (3) step();
      exp_q.push_back(2'd0);
      reset = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk($sformatf("rerelease_enter_e%0d", i), int'(enter), int'(i == 7));
      end
      btn_raw = 1'b0;
      repeat (12) step();

      chk("queue_drained", exp_q.size(), 0);
      chk("total_pulses", n_pulses, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
